usb_tx_bit_timer: RTL and testbench

Parametrised bit-timing strobe generator for the USB TX path; successor to the fixed full-speed output clock block. Fractional-N accumulator produces one-cycle bit strobes whose average period equals the USB bit time, e.g. 8,8,9 cycles for 12 Mbps from 100 MHz. Adds low-speed mode (LS_MULT sub-periods per bit), synchronous restart for packet alignment, and a running bit counter. Drives the TX shift register, bit-stuffer and NRZI encoder.

---
 rtl/usb_tx_bit_timer.sv | 177 +++++++++++++++++
 tb/tb_usb_tx_bit_timer.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/usb_tx_bit_timer.sv
// usb_tx_bit_timer: bit-timing strobe generator for the USB TX path.
// A fractional-N accumulator stretches some sub-periods by one clock cycle.
// This keeps the average bit period exact. For example, it gives 8,8,9 cycles
// per bit for 12 Mbps from 100 MHz.
// Full-speed mode uses one sub-period per bit. Low-speed mode uses LS_MULT
// sub-periods per bit.
//
// Optional feature macro: USB_TX_BIT_TIMER_MID_STROBE_EN
//   defined   -> mid_strobe pulses once per bit, at the bit midpoint
//   undefined -> mid_strobe tied low, no midpoint logic
//
// Ports:
//   clk           system clock, rising edge
//   n_rst         synchronous active-low reset
//   enable        run request (level)
//   ls_mode       1 = low-speed timing, latched on IDLE->RUN only
//   sync_restart  realign the bit boundary to this edge (RUN only)
//   bit_strobe    one-cycle pulse at each bit boundary
//   mid_strobe    one-cycle pulse at each bit midpoint (optional)
//   busy          high while running
//   bit_cnt       strobes since RUN entry or last restart (wraps)
module usb_tx_bit_timer #(
  parameter int unsigned FS_INT   = 8,
  parameter int unsigned FRAC_NUM = 1,
  parameter int unsigned FRAC_DEN = 3,
  parameter int unsigned LS_MULT  = 8,
  parameter int unsigned CNT_W    = 16
) (
  input  logic             clk,
  input  logic             n_rst,
  input  logic             enable,
  input  logic             ls_mode,
  input  logic             sync_restart,
  output logic             bit_strobe,
  output logic             mid_strobe,
  output logic             busy,
  output logic [CNT_W-1:0] bit_cnt
);

  localparam int unsigned ACC_W = $clog2(FRAC_DEN) + 1;
  localparam int unsigned CYC_W = $clog2(FS_INT + 2);
  localparam int unsigned SUB_W = $clog2(LS_MULT);

  // First sub-period after a fresh start, computed from an accumulator of zero
  localparam logic [ACC_W-1:0] ACC_FIRST =
    ACC_W'((FRAC_NUM >= FRAC_DEN) ? (FRAC_NUM - FRAC_DEN) : FRAC_NUM);
  localparam logic [CYC_W-1:0] LEN_FIRST =
    CYC_W'((FRAC_NUM >= FRAC_DEN) ? (FS_INT + 1) : FS_INT);

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  state_t           state;
  logic [ACC_W-1:0] acc;
  logic [CYC_W-1:0] cyc;
  logic [CYC_W-1:0] len;
  logic [SUB_W-1:0] sub_idx;
  logic             ls_q;

  logic [ACC_W-1:0] acc_sum;
  logic [ACC_W-1:0] acc_nxt;
  logic [CYC_W-1:0] len_nxt;
  logic             sub_done;
  logic             bit_end;

  // Next sub-period length and accumulator when the current sub-period ends
  always_comb begin
    acc_sum = acc + ACC_W'(FRAC_NUM);
    acc_nxt = acc_sum;
    len_nxt = CYC_W'(FS_INT);
    if (acc_sum >= ACC_W'(FRAC_DEN)) begin
      acc_nxt = acc_sum - ACC_W'(FRAC_DEN);
      len_nxt = CYC_W'(FS_INT + 1);
    end
  end

  // The current sub-period completes on the edge where cyc reaches len-1
  assign sub_done = (cyc == (len - CYC_W'(1)));
  assign bit_end  = !ls_q || (sub_idx == SUB_W'(LS_MULT - 1));

  // Control state, sub-period sequencing, bit strobe and counter
  always_ff @(posedge clk) begin
    if (!n_rst) begin
      state      <= IDLE;
      busy       <= 1'b0;
      bit_strobe <= 1'b0;
      bit_cnt    <= '0;
      cyc        <= '0;
      len        <= '0;
      acc        <= '0;
      sub_idx    <= '0;
      ls_q       <= 1'b0;
    end else begin
      bit_strobe <= 1'b0;
      case (state)
        IDLE: begin
          if (enable) begin
            state   <= RUN;
            busy    <= 1'b1;
            ls_q    <= ls_mode;
            acc     <= ACC_FIRST;
            len     <= LEN_FIRST;
            cyc     <= '0;
            sub_idx <= '0;
            bit_cnt <= '0;
          end
        end
        RUN: begin
          if (!enable) begin
            // Dropping enable wins over any boundary due on this edge
            state   <= IDLE;
            busy    <= 1'b0;
            acc     <= '0;
            len     <= '0;
            cyc     <= '0;
            sub_idx <= '0;
            bit_cnt <= '0;
          end else if (sync_restart) begin
            // A new first bit starts here; a boundary due now is dropped
            acc     <= ACC_FIRST;
            len     <= LEN_FIRST;
            cyc     <= '0;
            sub_idx <= '0;
            bit_cnt <= '0;
          end else if (sub_done) begin
            cyc <= '0;
            acc <= acc_nxt;
            len <= len_nxt;
            if (bit_end) begin
              bit_strobe <= 1'b1;
              bit_cnt    <= bit_cnt + CNT_W'(1);
              sub_idx    <= '0;
            end else begin
              sub_idx <= sub_idx + SUB_W'(1);
            end
          end else begin
            cyc <= cyc + CYC_W'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef USB_TX_BIT_TIMER_MID_STROBE_EN
  logic [CYC_W-1:0] half_m1;
  logic             mid_q;

  // In full-speed mode the midpoint is floor(L/2) cycles into the bit
  assign half_m1 = (len >> 1) - CYC_W'(1);

  // Midpoint pulse. Low-speed uses the end of sub-period LS_MULT/2.
  always_ff @(posedge clk) begin
    if (!n_rst) begin
      mid_q <= 1'b0;
    end else begin
      mid_q <= 1'b0;
      if ((state == RUN) && enable && !sync_restart) begin
        if (ls_q) begin
          if (sub_done && (sub_idx == SUB_W'(LS_MULT / 2 - 1))) begin
            mid_q <= 1'b1;
          end
        end else if (!sub_done && (cyc == half_m1)) begin
          mid_q <= 1'b1;
        end
      end
    end
  end

  assign mid_strobe = mid_q;
`else
  assign mid_strobe = 1'b0;
`endif

endmodule

// File: tb/tb_usb_tx_bit_timer.sv
// Self-checking bench for usb_tx_bit_timer.
// Expected bit intervals, counts and midpoint offsets are queued whenever
// stimulus starts a run. Each queued item is checked when its strobe arrives.
module tb_usb_tx_bit_timer;

  logic        clk = 1'b0;
  logic        n_rst;
  logic        enable;
  logic        ls_mode;
  logic        sync_restart;
  logic        bit_strobe;
  logic        mid_strobe;
  logic        busy;
  logic [15:0] bit_cnt;

  logic        en4;
  logic        strobe4;
  logic        mid4;
  logic        busy4;
  logic [3:0]  cnt4;

  int edge_cnt = 0;
  int checks = 0;
  int failures = 0;
  int last_edge = 0;
  int e0 = 0;

  typedef struct {
    int interval;
    int cnt;
    int mid_off;
  } exp_t;

  exp_t exp_q[$];

  usb_tx_bit_timer dut (
    .clk          (clk),
    .n_rst        (n_rst),
    .enable       (enable),
    .ls_mode      (ls_mode),
    .sync_restart (sync_restart),
    .bit_strobe   (bit_strobe),
    .mid_strobe   (mid_strobe),
    .busy         (busy),
    .bit_cnt      (bit_cnt)
  );

  usb_tx_bit_timer #(.CNT_W(4)) dut4 (
    .clk          (clk),
    .n_rst        (n_rst),
    .enable       (en4),
    .ls_mode      (1'b0),
    .sync_restart (1'b0),
    .bit_strobe   (strobe4),
    .mid_strobe   (mid4),
    .busy         (busy4),
    .bit_cnt      (cnt4)
  );

  always #5 clk = ~clk;

  always @(posedge clk) edge_cnt <= edge_cnt + 1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic push(input int interval, input int cnt, input int mid_off);
    exp_t e;
    e.interval = interval;
    e.cnt      = cnt;
    e.mid_off  = mid_off;
    exp_q.push_back(e);
  endtask

  // Wait (bounded) for the next strobe of the selected DUT, then score it
  task automatic expect_bit(input bit sel, input string tag);
    exp_t e;
    int   at;
    int   mids;
    int   mid_at;
    bit   got;
    got    = 1'b0;
    at     = 0;
    mids   = 0;
    mid_at = -1;
    for (int i = 0; i < 200 && !got; i++) begin
      @(negedge clk);
      if ((sel ? mid4 : mid_strobe) === 1'b1) begin
        mids++;
        mid_at = edge_cnt;
      end
      if ((sel ? strobe4 : bit_strobe) === 1'b1) begin
        got = 1'b1;
        at  = edge_cnt;
      end
    end
    check({tag, " strobe_seen"}, 32'(got), 32'd1);
    if (!got) return;
    checks++;
    assert (exp_q.size() > 0) else begin
      failures++;
      $error("FAIL %s scoreboard_empty observed=0 expected=1", tag);
    end
    if (exp_q.size() == 0) return;
    e = exp_q.pop_front();
    check({tag, " interval"}, at - last_edge, e.interval);
    check({tag, " bit_cnt"}, sel ? 32'(cnt4) : 32'(bit_cnt), e.cnt);
`ifdef USB_TX_BIT_TIMER_MID_STROBE_EN
    check({tag, " mid_count"}, mids, 1);
    check({tag, " mid_offset"}, mid_at - last_edge, e.mid_off);
`else
    check({tag, " mid_count"}, mids, 0);
`endif
    last_edge = at;
  endtask

  initial begin
    n_rst        = 1'b0;
    enable       = 1'b0;
    ls_mode      = 1'b0;
    sync_restart = 1'b0;
    en4          = 1'b0;

    // Reset state
    repeat (3) @(negedge clk);
    check("rst bit_strobe", 32'(bit_strobe), 0);
    check("rst mid_strobe", 32'(mid_strobe), 0);
    check("rst busy", 32'(busy), 0);
    check("rst bit_cnt", 32'(bit_cnt), 0);
    check("rst cnt4", 32'(cnt4), 0);
    n_rst = 1'b1;
    @(negedge clk);
    check("idle busy", 32'(busy), 0);

    // T1: full-speed, 36 bits in 300 cycles
    enable    = 1'b1;
    ls_mode   = 1'b0;
    e0        = edge_cnt + 1;
    last_edge = e0;
    for (int i = 1; i <= 36; i++) push(((i % 3) == 0) ? 9 : 8, i, 4);
    for (int i = 1; i <= 36; i++) begin
      expect_bit(1'b0, $sformatf("t1 bit%0d", i));
      if (i == 1) check("t1 busy", 32'(busy), 1);
    end
    check("t1 total_cycles", last_edge - e0, 300);
    check("t1 final_cnt", 32'(bit_cnt), 36);

    // T2: low-speed, 66/67/67; ls_mode change mid-run ignored
    enable = 1'b0;
    @(negedge clk);
    check("t2 idle busy", 32'(busy), 0);
    check("t2 idle bit_cnt", 32'(bit_cnt), 0);
    ls_mode   = 1'b1;
    enable    = 1'b1;
    e0        = edge_cnt + 1;
    last_edge = e0;
    push(66, 1, 33);
    push(67, 2, 34);
    push(67, 3, 33);
    expect_bit(1'b0, "t2 bit1");
    ls_mode = 1'b0;
    expect_bit(1'b0, "t2 bit2");
    expect_bit(1'b0, "t2 bit3");
    check("t2 total_cycles", last_edge - e0, 200);

    // T3: enable dropped exactly on the 3rd boundary
    enable = 1'b0;
    @(negedge clk);
    enable    = 1'b1;
    e0        = edge_cnt + 1;
    last_edge = e0;
    push(8, 1, 4);
    push(8, 2, 4);
    expect_bit(1'b0, "t3 bit1");
    expect_bit(1'b0, "t3 bit2");
    repeat (8) @(negedge clk);
    enable = 1'b0;
    @(negedge clk);
    check("t3 drop bit_strobe", 32'(bit_strobe), 0);
    check("t3 drop busy", 32'(busy), 0);
    check("t3 drop bit_cnt", 32'(bit_cnt), 0);
    check("t3 drop mid_strobe", 32'(mid_strobe), 0);
    enable    = 1'b1;
    last_edge = edge_cnt + 1;
    push(8, 1, 4);
    expect_bit(1'b0, "t3 reen");

    // T4: restart 5 cycles into bit 2, then restart on a boundary
    repeat (4) @(negedge clk);
    sync_restart = 1'b1;
    @(negedge clk);
    sync_restart = 1'b0;
    last_edge    = edge_cnt;
    check("t4 restart bit_cnt", 32'(bit_cnt), 0);
    check("t4 restart busy", 32'(busy), 1);
    push(8, 1, 4);
    push(8, 2, 4);
    push(9, 3, 4);
    expect_bit(1'b0, "t4 bit1");
    expect_bit(1'b0, "t4 bit2");
    expect_bit(1'b0, "t4 bit3");
    repeat (7) @(negedge clk);
    sync_restart = 1'b1;
    @(negedge clk);
    sync_restart = 1'b0;
    last_edge    = edge_cnt;
    check("t4b boundary bit_strobe", 32'(bit_strobe), 0);
    check("t4b boundary bit_cnt", 32'(bit_cnt), 0);
    push(8, 1, 4);
    expect_bit(1'b0, "t4b bit1");

    // T6: one-cycle reset mid-run; enable is resampled afterwards
    repeat (3) @(negedge clk);
    n_rst = 1'b0;
    @(negedge clk);
    check("t6 rst bit_strobe", 32'(bit_strobe), 0);
    check("t6 rst mid_strobe", 32'(mid_strobe), 0);
    check("t6 rst busy", 32'(busy), 0);
    check("t6 rst bit_cnt", 32'(bit_cnt), 0);
    n_rst     = 1'b1;
    last_edge = edge_cnt + 1;
    push(8, 1, 4);
    expect_bit(1'b0, "t6 bit1");
    push(8, 2, 4);
    expect_bit(1'b0, "t6 bit2");

    // T5: 4-bit counter wraps 15 -> 0 -> 1 with unchanged spacing
    enable = 1'b0;
    @(negedge clk);
    check("t5 idle cnt4", 32'(cnt4), 0);
    en4       = 1'b1;
    last_edge = edge_cnt + 1;
    for (int i = 1; i <= 17; i++) push(((i % 3) == 0) ? 9 : 8, i % 16, 4);
    for (int i = 1; i <= 17; i++) expect_bit(1'b1, $sformatf("t5 bit%0d", i));
    check("t5 busy4", 32'(busy4), 1);
    en4 = 1'b0;
    @(negedge clk);
    check("t5 stop cnt4", 32'(cnt4), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
